// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the clocked program memory: FSM states,
// the NOP fill word, and the address range check used on fetch and load.
package prog_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // NOP encoding, also used by the assembler include as the padding word.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Operands are widened to 64 bits so callers can compare the full PC.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// Simple dual-port synchronous RAM with one write port and one registered
// read port; a same-address read and write returns the old word.
module prog_mem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prog_mem_ctrl.sv
// Clocked instruction memory: clears itself to FILL_WORD after reset, then
// serves PC fetches with one-cycle latency and accepts run-time loads.
module prog_mem_ctrl
  import prog_mem_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              DEPTH      = 256,
  parameter int              ADDR_W     = $clog2(DEPTH),
  parameter int              PC_W       = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(NOP_WORD),
  parameter bit              INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic              flush,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_fault,
  input  logic              load_en,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy,
  output state_e            dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam state_e            RESET_STATE = INIT_CLEAR ? ST_CLEAR : ST_RUN;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              inst_valid_q, inst_fault_q, data_sel_q;
  logic              run, accept, pc_ok, load_ok;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = RESET_STATE;
    endcase
  end

  // Clear pointer stops at the last word; the FSM leaves CLEAR on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q <= '0;
    end else if (state_q == ST_CLEAR && clr_addr_q != LAST_ADDR) begin
      clr_addr_q <= clr_addr_q + 1'b1;
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and the sender holds its payload until then.
  always_comb begin
    run         = (state_q == ST_RUN);
    pc_ok       = addr_in_range(64'(fetch_pc), 64'(DEPTH));
    load_ok     = addr_in_range(64'(load_addr), 64'(DEPTH));
    fetch_ready = run && !flush && (!inst_valid_q || inst_ready);
    accept      = fetch_valid && fetch_ready;
    ram_re      = accept && pc_ok;
    ram_we      = 1'b0;
    ram_waddr   = load_addr;
    ram_wdata   = load_data;
    if (!run) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = FILL_WORD;
    end else if (load_en && load_ok) begin
      ram_we    = 1'b1;
    end
  end

  prog_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fetch_pc[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // RAM read data only moves on an accepted fetch, so it doubles as the
  // held output word; data_sel_q picks FILL_WORD after reset or a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid_q <= 1'b0;
      inst_fault_q <= 1'b0;
      data_sel_q   <= 1'b0;
    end else if (accept) begin
      inst_valid_q <= 1'b1;
      inst_fault_q <= !pc_ok;
      data_sel_q   <= pc_ok;
    end else if (flush || inst_ready) begin
      inst_valid_q <= 1'b0;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_fault = inst_fault_q;
  assign inst_data  = data_sel_q ? ram_rdata : FILL_WORD;
  assign load_ready = run;
  assign busy       = !run;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Self-checking bench for prog_mem_ctrl with default parameters (DEPTH=256).
module tb_prog_mem_ctrl;
  import prog_mem_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int PC_W   = 32;
  localparam logic [DATA_W-1:0] FILL = 32'h0000_0000;
  localparam logic [DATA_W-1:0] W0 = 32'h0022_1820;
  localparam logic [DATA_W-1:0] W1 = 32'h0043_1820;
  localparam logic [DATA_W-1:0] W2 = 32'h0064_1820;

  logic              clk, rst_n;
  logic              fetch_valid, fetch_ready, flush;
  logic [PC_W-1:0]   fetch_pc;
  logic              inst_valid, inst_ready, inst_fault;
  logic [DATA_W-1:0] inst_data;
  logic              load_en, load_ready, busy;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  state_e            dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_lat = 0;
  logic [DATA_W:0] exp_q[$];
  int              lat_q[$];
  logic [DATA_W:0] mon_e;
  int              mon_t;
  int              cnt;

  prog_mem_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .flush       (flush),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_fault  (inst_fault),
    .load_en     (load_en),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop on output handshake, discard on flush of a held word
  always @(negedge clk) begin
    if (rst_n && inst_valid && (inst_ready || flush)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 64'(inst_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = lat_q.pop_front();
        if (inst_ready) begin
          check("sb_data", 64'(inst_data), 64'(mon_e[DATA_W-1:0]));
          check("sb_fault", 64'(inst_fault), 64'(mon_e[DATA_W]));
          if (chk_lat) check("sb_latency", 64'(cyc - mon_t), 64'd1);
        end
      end
    end
  end

  // driver tasks: all called at posedge+1
  task automatic do_fetch(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] ed,
                          input logic ef);
    int w = 0;
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    @(negedge clk);
    while (!fetch_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!fetch_ready) begin
      check("fetch_timeout", 64'd0, 64'd1);
    end else begin
      exp_q.push_back({ef, ed});
      lat_q.push_back(cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    fetch_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    check("load_ready", 64'(load_ready), 64'd1);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk); #1;
    load_en   = 1'b0;
  endtask

  // called at a negedge just after rst_n rises; counts cycles with busy high
  task automatic wait_clear(output int c);
    c = 0;
    while (busy && c < 1000) begin
      c++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; flush = 1'b0;
    inst_ready = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_data", 64'(inst_data), 64'(FILL));
    check("rst_inst_fault", 64'(inst_fault), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(ST_CLEAR));

    rst_n = 1'b1;
    wait_clear(cnt);
    check("clear_cycles", 64'(cnt), 64'd256);
    check("run_load_ready", 64'(load_ready), 64'd1);
    check("run_fetch_ready", 64'(fetch_ready), 64'd1);
    check("run_state", 64'(dbg_state), 64'(ST_RUN));
    @(posedge clk); #1;

    // cleared contents
    chk_lat = 1;
    do_fetch(32'd0, FILL, 1'b0);
    do_fetch(32'd17, FILL, 1'b0);
    do_fetch(32'd255, FILL, 1'b0);
    idle(2);

    // load then back-to-back stream
    do_load(8'd0, W0);
    do_load(8'd1, W1);
    do_load(8'd2, W2);
    do_fetch(32'd0, W0, 1'b0);
    do_fetch(32'd1, W1, 1'b0);
    do_fetch(32'd2, W2, 1'b0);
    idle(2);

    // backpressure
    chk_lat = 0;
    inst_ready = 1'b0;
    do_fetch(32'd1, W1, 1'b0);
    fetch_valid = 1'b1;
    fetch_pc    = 32'd2;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", 64'(inst_valid), 64'd1);
      check("bp_data", 64'(inst_data), 64'(W1));
      check("bp_ready", 64'(fetch_ready), 64'd0);
      @(posedge clk); #1;
    end
    inst_ready = 1'b1;
    do_fetch(32'd2, W2, 1'b0);
    idle(2);

    // out of range, then array unchanged
    chk_lat = 1;
    do_fetch(32'd256, FILL, 1'b1);
    do_fetch(32'hFFFF_FFFF, FILL, 1'b1);
    do_fetch(32'd0, W0, 1'b0);
    do_fetch(32'd255, FILL, 1'b0);
    idle(2);

    // same-cycle load and fetch: old word first
    load_en = 1'b1; load_addr = 8'd5; load_data = 32'hDEAD_BEEF;
    do_fetch(32'd5, FILL, 1'b0);
    load_en = 1'b0;
    do_fetch(32'd5, 32'hDEAD_BEEF, 1'b0);
    idle(2);

    // flush of a held word
    chk_lat = 0;
    inst_ready = 1'b0;
    do_fetch(32'd2, W2, 1'b0);
    fetch_valid = 1'b0;
    @(negedge clk);
    check("fl_valid_before", 64'(inst_valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("fl_ready", 64'(fetch_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fl_valid_after", 64'(inst_valid), 64'd0);
    @(posedge clk); #1;

    // flush together with an output handshake: no new fetch
    do_fetch(32'd0, W0, 1'b0);
    fetch_valid = 1'b1; fetch_pc = 32'd1; flush = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    check("flhs_ready", 64'(fetch_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; fetch_valid = 1'b0;
    @(negedge clk);
    check("flhs_valid", 64'(inst_valid), 64'd0);

    // reset in the middle of CLEAR at address 100
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("midclr_reached", 64'(cnt), 64'd100);
    rst_n = 1'b0;
    #1;
    check("midclr_busy", 64'(busy), 64'd1);
    check("midclr_state", 64'(dbg_state), 64'(ST_CLEAR));
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(cnt);
    check("reclear_cycles", 64'(cnt), 64'd256);
    @(posedge clk); #1;
    chk_lat = 1;
    do_fetch(32'd5, FILL, 1'b0);
    do_fetch(32'd1, FILL, 1'b0);
    idle(3);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
